// File: rtl/mixcol_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// One shared GF(2^8) multiplier computes all 64 coefficient products of a 128-bit state, one per clock.

module gf_mul8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    logic [14:0] prod_s;

    // Carry-less 8x8 product, then fold bits 14..8 back with 0x11B.
    always_comb begin
        prod_s = 15'd0;
        for (int i = 0; i < 8; i++) begin
            prod_s = prod_s ^ ({15{b_i[i]}} & ({7'd0, a_i} << i));
        end
        for (int i = 14; i >= 8; i--) begin
            prod_s = prod_s ^ ({15{prod_s[i]}} & (15'h011B << (i - 8)));
        end
        p_o = prod_s[7:0];
    end

endmodule

module mixcol_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   step_q, step_d;
    logic [7:0]   acc_q, acc_d;
    logic [127:0] src_q, src_d;
    logic         mode_q, mode_d;
    logic [127:0] out_q, out_d;

    logic [3:0]   b_s;
    logic [1:0]   k_s;
    logic [1:0]   r_s;
    logic [1:0]   c_s;
    logic [7:0]   coef_s;
    logic [7:0]   src_byte_s;
    logic [7:0]   prod_s;

    // Row-0 coefficients, rotated by (k - r) mod 4 to give coef(r,k).
    function automatic logic [7:0] coef_f(input logic inv, input logic [1:0] sel);
        logic [7:0] c;
        case ({inv, sel})
            3'b000:  c = 8'h02;
            3'b001:  c = 8'h03;
            3'b010:  c = 8'h01;
            3'b011:  c = 8'h01;
            3'b100:  c = 8'h0E;
            3'b101:  c = 8'h0B;
            3'b110:  c = 8'h0D;
            3'b111:  c = 8'h09;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Byte i of a state lives at bits [127-8i -: 8]; 127-8i == {~i, 3'b111}.
    function automatic logic [7:0] byte_sel_f(input logic [127:0] st, input logic [3:0] idx);
        return st[{~idx, 3'b111} -: 8];
    endfunction

    // Decode the step counter into output byte and term index, then form the product operands.
    always_comb begin
        b_s        = step_q[5:2];
        k_s        = step_q[1:0];
        c_s        = b_s[3:2];
        r_s        = b_s[1:0];
        coef_s     = coef_f(mode_q, k_s - r_s);
        src_byte_s = byte_sel_f(src_q, {c_s, k_s});
    end

    gf_mul8 u_gf_mul8 (
        .a_i (coef_s),
        .b_i (src_byte_s),
        .p_o (prod_s)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        src_d   = src_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MUL;
                    src_d   = in_data;
                    mode_d  = in_inv;
                    step_d  = 6'd0;
                    acc_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                step_d = step_q + 6'd1;
                if (k_s == 2'd3) begin
                    out_d[{~b_s, 3'b111} -: 8] = acc_q ^ prod_s;
                    acc_d                      = 8'd0;
                end else begin
                    acc_d = acc_q ^ prod_s;
                end
                if (step_q == 6'd63) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= 6'd0;
            acc_q   <= 8'd0;
            src_q   <= 128'd0;
            mode_q  <= 1'b0;
            out_q   <= 128'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            src_q   <= src_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DONE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed bench for mixcol_seq: vector table plus backpressure, ignored-input and mid-operation reset sequences.

module tb_mixcol_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[3];

    mixcol_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one state, measure latency to out_valid; result is left pending in DONE.
    task automatic start_and_wait(input logic [127:0] din, input logic inv, input string name,
                                  input bit toggle_during);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        check({name, " in_ready before accept"}, {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_data  = din;
        in_inv   = inv;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            if (toggle_during && cnt < 60) begin
                in_valid = ~in_valid;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_inv   = ~in_inv;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 128'(cnt), 128'd64);
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " in_ready after handshake"}, {127'd0, in_ready}, 128'd1);
        check({name, " out_valid after handshake"}, {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        logic [127:0] held;
        bit           stable;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{din: 128'hdb135345_f20a225c_01010101_c6c6c6c6, inv: 1'b0,
                    dout: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{din: 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, inv: 1'b0,
                    dout: 128'h046681e5_e0cb199a_48f8d37a_2806264c};
        vecs[2] = '{din: 128'h046681e5_e0cb199a_48f8d37a_2806264c, inv: 1'b1,
                    dout: 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset in_ready", {127'd0, in_ready}, 128'd1);
        check("reset out_valid", {127'd0, out_valid}, 128'd0);
        check("reset busy", {127'd0, busy}, 128'd0);
        check("reset out_data", out_data, 128'd0);

        for (int i = 0; i < 3; i++) begin
            start_and_wait(vecs[i].din, vecs[i].inv, $sformatf("vec%0d", i), 1'b0);
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].dout);
            check($sformatf("vec%0d busy in DONE", i), {127'd0, busy}, 128'd1);
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure with junk input activity during MUL.
        start_and_wait(vecs[0].din, 1'b0, "bp", 1'b1);
        check("bp out_data", out_data, vecs[0].dout);
        held   = out_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || out_data !== held) stable = 1'b0;
        end
        check("bp stable for 20 cycles", {127'd0, stable}, 128'd1);
        check("bp out_data after wait", out_data, vecs[0].dout);
        release_result("bp");

        // Reset at step 30 aborts the operation.
        in_valid = 1'b1;
        in_data  = vecs[1].din;
        in_inv   = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        check("midrst busy before reset", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst busy", {127'd0, busy}, 128'd0);
        check("midrst out_data", out_data, 128'd0);

        start_and_wait({16{8'hc6}}, 1'b0, "c6", 1'b0);
        check("c6 out_data", out_data, {16{8'hc6}});
        release_result("c6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
